// File: rtl/liv_trasporto_tx_pacco_fifo_pkg.sv
// Shared types for the transport TX path: stream word layout and write-FSM states.
package pkg_trasporto;

   localparam int ETH_WORD_W = 32;
   localparam int ETH_KEEP_W = ETH_WORD_W / 8;

   typedef struct packed {
      logic [ETH_WORD_W-1:0] data;
      logic [ETH_KEEP_W-1:0] keep;
      logic                  last;
   } stream_word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } wr_state_e;

endpackage

// File: rtl/liv_trasporto_tx_pacco_fifo_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module ram_dp_sync #(
   parameter int WIDTH = 37,
   parameter int AW    = 11
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/liv_trasporto_tx_pacco_fifo.sv
// Store-and-forward TX packet FIFO between the transport stage and the MAC stream.
// Optional frame statistics are enabled with the macro TX_PACCO_FIFO_STATS_EN.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | between frames, next valid word starts a new frame
// ST_RECV | storing an uncommitted frame beyond wr_c
// ST_DROP | frame already rejected, discarding until its last word
module liv_trasporto_tx_pacco_fifo
   import pkg_trasporto::*;
#(
   parameter int DEPTH_LOG2 = 11,
   parameter int PKT_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic [ETH_WORD_W-1:0] i_s_data,
   input  logic [ETH_KEEP_W-1:0] i_s_keep,
   input  logic                  i_s_valid,
   input  logic                  i_s_last,
   input  logic                  i_m_ready,
   output logic [ETH_WORD_W-1:0] o_m_data,
   output logic [ETH_KEEP_W-1:0] o_m_keep,
   output logic                  o_m_valid,
   output logic                  o_m_last,
   output logic                  od_pacco_scartato,
   output logic [PKT_CNT_W-1:0]  od_pkt_count,
`ifdef TX_PACCO_FIFO_STATS_EN
   input  logic                  i_stat_clr,
   output logic [15:0]           od_stat_inviati,
   output logic [15:0]           od_stat_scartati,
`endif
   output logic                  od_vuoto
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
   localparam logic [PW-1:0]        USED_MAX = PW'((1 << DEPTH_LOG2) - 1);
   localparam logic [PKT_CNT_W-1:0] CNT_ONE  = PKT_CNT_W'(1);
   localparam logic [PKT_CNT_W-1:0] CNT_MAX  = '1;

   wr_state_e    state, state_nxt;
   logic [PW-1:0] wr, wr_nxt, wr_c, wr_c_nxt, rd, rd_nxt, used;
   logic          we, commit, drop, has_space, cnt_sat;

   stream_word_t  wword, rword, head, tail;
   logic [1:0]    occ;
   logic [2:0]    occ_after;
   logic          ren, pend, pop, push, sent_last;

   assign wword     = {i_s_data, i_s_keep, i_s_last};
   assign used      = wr - rd;
   assign has_space = (used != USED_MAX);
   assign cnt_sat   = (od_pkt_count == CNT_MAX);

   always_comb begin
      state_nxt = state;
      wr_nxt    = wr;
      wr_c_nxt  = wr_c;
      we        = 1'b0;
      commit    = 1'b0;
      drop      = 1'b0;
      case (state)
         ST_IDLE: if (i_s_valid) begin
            if (cnt_sat || !has_space) begin
               drop = 1'b1;
               if (!i_s_last) state_nxt = ST_DROP;
            end else begin
               we     = 1'b1;
               wr_nxt = wr + PTR_ONE;
               if (i_s_last) begin
                  wr_c_nxt = wr + PTR_ONE;
                  commit   = 1'b1;
               end else begin
                  state_nxt = ST_RECV;
               end
            end
         end
         ST_RECV: if (i_s_valid) begin
            if (has_space) begin
               we     = 1'b1;
               wr_nxt = wr + PTR_ONE;
               if (i_s_last) begin
                  wr_c_nxt  = wr + PTR_ONE;
                  commit    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               // Out of room: forget the partial frame and swallow the rest.
               wr_nxt    = wr_c;
               drop      = 1'b1;
               state_nxt = i_s_last ? ST_IDLE : ST_DROP;
            end
         end
         ST_DROP: if (i_s_valid && i_s_last) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Prefetch only committed words, and only while the 2-entry stage will have room
   // once the read in flight lands.
   assign pop       = o_m_valid && i_m_ready;
   assign push      = pend;
   assign sent_last = pop && head.last;
   assign occ_after = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
   assign ren       = (rd != wr_c) && (occ_after < 3'd2);
   assign rd_nxt    = ren ? rd + PTR_ONE : rd;

   ram_dp_sync #(
      .WIDTH ($bits(stream_word_t)),
      .AW    (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr[DEPTH_LOG2-1:0]),
      .wdata (wword),
      .re    (ren),
      .raddr (rd[DEPTH_LOG2-1:0]),
      .rdata (rword)
   );

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         wr    <= '0;
         wr_c  <= '0;
         rd    <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         wr    <= wr_nxt;
         wr_c  <= wr_c_nxt;
         rd    <= rd_nxt;
         pend  <= ren;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= rword;
               else             tail <= rword;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= rword;
               end else begin
                  head <= tail;
                  tail <= rword;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_m_valid = (occ != 2'd0);
   assign o_m_data  = head.data;
   assign o_m_keep  = head.keep;
   assign o_m_last  = head.last;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         od_pkt_count      <= '0;
         od_pacco_scartato <= 1'b0;
         od_vuoto          <= 1'b1;
      end else begin
         if (commit && !sent_last)      od_pkt_count <= od_pkt_count + CNT_ONE;
         else if (sent_last && !commit) od_pkt_count <= od_pkt_count - CNT_ONE;
         od_pacco_scartato <= drop;
         od_vuoto          <= (wr_nxt == rd_nxt);
      end
   end

`ifdef TX_PACCO_FIFO_STATS_EN
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         od_stat_inviati  <= '0;
         od_stat_scartati <= '0;
      end else if (i_stat_clr) begin
         od_stat_inviati  <= '0;
         od_stat_scartati <= '0;
      end else begin
         if (sent_last && od_stat_inviati != 16'hFFFF)  od_stat_inviati  <= od_stat_inviati + 16'd1;
         if (drop && od_stat_scartati != 16'hFFFF)      od_stat_scartati <= od_stat_scartati + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_liv_trasporto_tx_pacco_fifo.sv
// Scoreboard bench for the TX packet FIFO at DEPTH_LOG2=4 (15 usable words).
module tb_liv_trasporto_tx_pacco_fifo;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_s_data;
   logic [3:0]  i_s_keep;
   logic        i_s_valid, i_s_last, i_m_ready;
   logic [31:0] o_m_data;
   logic [3:0]  o_m_keep;
   logic        o_m_valid, o_m_last, od_pacco_scartato, od_vuoto;
   logic [7:0]  od_pkt_count;
`ifdef TX_PACCO_FIFO_STATS_EN
   logic        i_stat_clr = 1'b0;
   logic [15:0] od_stat_inviati, od_stat_scartati;
`endif

   liv_trasporto_tx_pacco_fifo #(.DEPTH_LOG2(4), .PKT_CNT_W(8)) dut (
      .clk               (clk),
      .i_rst_n           (i_rst_n),
      .i_s_data          (i_s_data),
      .i_s_keep          (i_s_keep),
      .i_s_valid         (i_s_valid),
      .i_s_last          (i_s_last),
      .i_m_ready         (i_m_ready),
      .o_m_data          (o_m_data),
      .o_m_keep          (o_m_keep),
      .o_m_valid         (o_m_valid),
      .o_m_last          (o_m_last),
      .od_pacco_scartato (od_pacco_scartato),
      .od_pkt_count      (od_pkt_count),
`ifdef TX_PACCO_FIFO_STATS_EN
      .i_stat_clr        (i_stat_clr),
      .od_stat_inviati   (od_stat_inviati),
      .od_stat_scartati  (od_stat_scartati),
`endif
      .od_vuoto          (od_vuoto)
   );

   always #2 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          beat_cnt = 0;
   int          drop_cnt = 0;
   logic [36:0] exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pops on every transfer, plus hold checks while stalled.
   logic [36:0] cur, prev_w, e;
   logic        prev_v, prev_r, have_prev = 1'b0;
   assign cur = {o_m_data, o_m_keep, o_m_last};

   always @(negedge clk) begin
      if (!i_rst_n) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev && prev_v && !prev_r) begin
            chk("hold_valid", {63'd0, o_m_valid}, 64'd1);
            chk("hold_word", {27'd0, cur}, {27'd0, prev_w});
         end
         if (o_m_valid && i_m_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexp_beat: got %h with no beat expected", cur);
            end else begin
               e = exp_q.pop_front();
               chk("beat_word", {27'd0, cur}, {27'd0, e});
            end
            beat_cnt++;
         end
         if (od_pacco_scartato) drop_cnt++;
         prev_v    = o_m_valid;
         prev_r    = i_m_ready;
         prev_w    = cur;
         have_prev = 1'b1;
      end
   end

   task automatic send_frame(input int n, input logic [7:0] tag, input logic [3:0] kl, input bit keep_it);
      for (int i = 0; i < n; i++) begin
         i_s_valid = 1'b1;
         i_s_data  = {tag, 24'(i)};
         i_s_last  = (i == n - 1);
         i_s_keep  = (i == n - 1) ? kl : 4'hF;
         if (keep_it) exp_q.push_back({i_s_data, i_s_keep, i_s_last});
         @(posedge clk); #1;
      end
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      i_s_data  = '0;
      i_s_keep  = '0;
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(nm, 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, d0, lat, bub, k;
      logic [15:0] rpat;
      rpat      = 16'b0110_1001_1011_0010;
      i_rst_n   = 1'b0;
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      i_s_data  = '0;
      i_s_keep  = '0;
      i_m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, o_m_valid}, 64'd0);
      chk("rst_data", {32'd0, o_m_data}, 64'd0);
      chk("rst_vuoto", {63'd0, od_vuoto}, 64'd1);
      chk("rst_cnt", {56'd0, od_pkt_count}, 64'd0);
      chk("rst_drop", {63'd0, od_pacco_scartato}, 64'd0);
      i_rst_n = 1'b1;
      @(posedge clk); #1;

      // single 5-word frame, ready high
      i_m_ready = 1'b1;
      b0 = beat_cnt;
      send_frame(5, 8'hA1, 4'h7, 1'b1);
      chk("t1_cnt_commit", {56'd0, od_pkt_count}, 64'd1);
      lat = 0;
      while (!o_m_valid && lat < 3) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("t1_latency_valid", {63'd0, o_m_valid}, 64'd1);
      wait_drain("t1_drain", 100);
      chk("t1_beats", 64'(beat_cnt - b0), 64'd5);
      chk("t1_cnt_end", {56'd0, od_pkt_count}, 64'd0);
      chk("t1_vuoto", {63'd0, od_vuoto}, 64'd1);

      // three frames stored under backpressure, then streamed
      i_m_ready = 1'b0;
      b0 = beat_cnt;
      send_frame(3, 8'hB1, 4'h3, 1'b1);
      send_frame(4, 8'hB2, 4'h1, 1'b1);
      send_frame(2, 8'hB3, 4'hF, 1'b1);
      chk("t2_cnt3", {56'd0, od_pkt_count}, 64'd3);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_stalled_valid", {63'd0, o_m_valid}, 64'd1);
      i_m_ready = 1'b1;
      bub = 0;
      repeat (9) begin
         @(negedge clk);
         if (!o_m_valid) bub++;
      end
      chk("t2_bubbles", 64'(bub), 64'd0);
      @(posedge clk); #1;
      wait_drain("t2_drain", 100);
      chk("t2_beats", 64'(beat_cnt - b0), 64'd9);
      chk("t2_cnt_end", {56'd0, od_pkt_count}, 64'd0);

      // oversize frame into empty FIFO, then a small frame
      d0 = drop_cnt;
      b0 = beat_cnt;
      send_frame(16, 8'hC1, 4'hF, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("t3_drop_pulses", 64'(drop_cnt - d0), 64'd1);
      chk("t3_no_beats", 64'(beat_cnt - b0), 64'd0);
      chk("t3_vuoto", {63'd0, od_vuoto}, 64'd1);
      chk("t3_cnt", {56'd0, od_pkt_count}, 64'd0);
      send_frame(2, 8'hC2, 4'h3, 1'b1);
      wait_drain("t3_drain", 100);
      chk("t3_beats_after", 64'(beat_cnt - b0), 64'd2);

      // second frame does not fit behind an unsent 10-word frame
      i_m_ready = 1'b0;
      d0 = drop_cnt;
      b0 = beat_cnt;
      send_frame(10, 8'hD1, 4'hE, 1'b1);
      send_frame(8, 8'hD2, 4'hF, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_drop_pulses", 64'(drop_cnt - d0), 64'd1);
      chk("t4_cnt1", {56'd0, od_pkt_count}, 64'd1);
      i_m_ready = 1'b1;
      wait_drain("t4_drain", 100);
      chk("t4_beats", 64'(beat_cnt - b0), 64'd10);
      chk("t4_cnt_end", {56'd0, od_pkt_count}, 64'd0);

      // ready toggling on a 7-word frame
      i_m_ready = 1'b0;
      b0 = beat_cnt;
      send_frame(7, 8'hE1, 4'h1, 1'b1);
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
         i_m_ready = rpat[i % 16];
         @(posedge clk); #1;
      end
      chk("t5_drain", 64'(exp_q.size()), 64'd0);
      i_m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_beats", 64'(beat_cnt - b0), 64'd7);
      chk("t5_cnt_end", {56'd0, od_pkt_count}, 64'd0);

      // reset while a frame is being read out
      send_frame(6, 8'hF1, 4'hF, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      i_m_ready = 1'b1;
      b0 = beat_cnt;
      k = 0;
      while ((beat_cnt - b0) < 2 && k < 20) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("t6_beats_before_rst", 64'(beat_cnt - b0), 64'd2);
      i_rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rst_valid", {63'd0, o_m_valid}, 64'd0);
      chk("t6_rst_data", {32'd0, o_m_data}, 64'd0);
      chk("t6_rst_last", {63'd0, o_m_last}, 64'd0);
      chk("t6_rst_vuoto", {63'd0, od_vuoto}, 64'd1);
      chk("t6_rst_cnt", {56'd0, od_pkt_count}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge clk); #1;
      b0 = beat_cnt;
      send_frame(4, 8'hF2, 4'h3, 1'b1);
      wait_drain("t6_drain", 100);
      chk("t6_beats_after", 64'(beat_cnt - b0), 64'd4);
      chk("t6_cnt_end", {56'd0, od_pkt_count}, 64'd0);
      chk("t6_vuoto_end", {63'd0, od_vuoto}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
